// File: rtl/key_event_decoder_if.sv
// Key-level in, classified one-clock strobes out, between a debouncer and the timer control FSM.
// The debouncer/controller side uses the master modport; the decoder uses the slave modport.
interface key_event_decoder_if;
  logic key_press;
  logic repeat_en;
  logic press_pulse;
  logic release_pulse;
  logic short_click;
  logic long_press;
  logic repeat_pulse;
  logic held;

  modport master (
    output key_press,
    output repeat_en,
    input  press_pulse,
    input  release_pulse,
    input  short_click,
    input  long_press,
    input  repeat_pulse,
    input  held
  );

  modport slave (
    input  key_press,
    input  repeat_en,
    output press_pulse,
    output release_pulse,
    output short_click,
    output long_press,
    output repeat_pulse,
    output held
  );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies each debounced key hold into press/release edges, short click, long press
// and auto-repeat ticks; every output is registered, strobes last exactly one clock.
module key_event_decoder #(
  parameter int CNT_W         = 25,
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  key_event_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic press_q,   press_d;
  logic release_q, release_d;
  logic short_q,   short_d;
  logic long_q,    long_d;
  logic repeat_q,  repeat_d;
  logic held_q,    held_d;

  // NOTE: every variable gets a default before any branch so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.key_press) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end

      PRESSED: begin
        // Release is tested first so it wins over the long-press terminal count.
        if (!bus.key_press) begin
          state_d   = IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
        end else if (cnt_q == LONG_LAST) begin
          state_d = LONG;
          cnt_d   = '0;
          long_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      LONG: begin
        if (!bus.key_press) begin
          state_d   = IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (!bus.repeat_en) begin
          // Holding the count at zero restarts repeat timing when repeat_en rises.
          cnt_d = '0;
        end else if (cnt_q == REPEAT_LAST) begin
          cnt_d    = '0;
          repeat_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d != IDLE);
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.short_click   = short_q;
  assign bus.long_press    = long_q;
  assign bus.repeat_pulse  = repeat_q;
  assign bus.held          = held_q;

endmodule
